xg_tx_frame_fifo: RTL
=====================

Name: xg_tx_frame_fifo

Overview:
Parametrised store-and-forward transmit frame buffer that feeds the 10G MAC client TX interface (tx_data / tx_data_valid / tx_start / tx_ack). It accepts frames from user logic as a ready/valid word stream and releases a frame to the MAC only once it is fully stored. This guarantees that the MAC never sees a gap after tx_ack, so the FIFO never has to assert tx_underrun for a stored frame. It generalises the fixed 64-bit MAC client path to any width and depth, and adds frame drop, error discard and statistics.

Parameters:
DATA_W, 64, data word width in bits; multiple of 8; 64 for XGMAC.
KEEP_W, DATA_W/8, byte-valid width; derived, not overridable.
DEPTH, 512, word entries in buffer; power of 2, min 4.
CNT_W, 32, width of statistics counters.

Ports:
tx_clk0  in  1  single clock for the whole block (MAC TX clock).
reset_n  in  1  asynchronous, active-low reset.
wr_data  in  DATA_W  client data word.
wr_keep  in  KEEP_W  byte valid; bit0 = lowest byte.
wr_last  in  1  last word of frame.
wr_err  in  1  client marks frame bad; frame is discarded.
wr_valid  in  1  word present.
wr_ready  out  1  FIFO accepts word this cycle.
tx_data  out  DATA_W  to MAC tx_data.
tx_data_valid  out  KEEP_W  to MAC tx_data_valid.
tx_start  out  1  to MAC tx_start.
tx_ack  in  1  from MAC.
tx_underrun  out  1  to MAC; held 0 (store-and-forward).
frames_sent  out  CNT_W  saturating count of frames fully sent.
frames_dropped  out  CNT_W  saturating count of discarded frames.
fifo_level  out  $clog2(DEPTH)+1  words currently stored, committed plus partial.

Behaviour:
- Reset (async assert, sync release): all pointers, counters and FSM cleared. wr_ready=0 while reset_n=0, then 1. tx_start=0, tx_data=0, tx_data_valid=0, tx_underrun=0, counters=0, fifo_level=0. A partial or in-flight frame is lost on reset.
- Pointers: wr_ptr (speculative), commit_ptr and rd_ptr, each $clog2(DEPTH)+1 bits with an extra wrap bit. full = (wr_ptr - rd_ptr) == DEPTH.
- Write: a word is accepted when wr_valid && wr_ready. Entry stored = {last, keep, data}.
- Commit: on an accepted word with wr_last=1 and the frame not marked bad, set commit_ptr <= wr_ptr+1 and increment frames_avail.
- Bad frame: marked bad if any accepted word has wr_err=1. It is also bad if a non-last word has keep != all ones, or if a last word has keep == 0 or non-contiguous keep (not of form 0..01..1).
  - When the bad frame's last word is accepted: wr_ptr <= commit_ptr and frames_dropped increments.
- Oversize: full, frame in progress, and frames_avail==0.
  - Enter DISCARD mode: wr_ready=1, words are consumed but not stored, wr_ptr <= commit_ptr.
  - On wr_last, frames_dropped increments and the block returns to normal.
  - Otherwise, when full, wr_ready=0.
- Read FSM states: IDLE, START, SEND.
  - IDLE: when frames_avail>0, load word at rd_ptr into output registers, tx_start=1, go to START (1 cycle after frames_avail rises).
  - START: hold tx_data/tx_data_valid = first word and tx_start=1 until tx_ack. In the cycle tx_ack=1, drop tx_start. If the first word's last=1, the frame is done; otherwise present the next word on the following cycle and go to SEND.
  - SEND: present one new word every cycle with no gaps. After the word with last=1, go to IDLE, or directly to START if frames_avail>1 (back-to-back; the MAC inserts IFG).
  - Outside START/SEND, tx_data_valid=0 and tx_data=0.
- Frame completion: rd_ptr advances past the last word, frames_avail decrements, frames_sent increments.
- Simultaneous commit and frame completion: frames_avail unchanged.
- Wrap-around: pointers wrap modulo 2*DEPTH; RAM addresses use the low bits.
- Counters saturate at all ones.
- Read latency: the RAM has a 1-cycle registered read; the FSM prefetches so that SEND never stalls.

Decomposition:
- Package xg_pkg: txf_state_t enum {IDLE, START, SEND}; function keep_contig(keep) returning 1 if keep is nonzero and of form 0..01..1; localparam-derived KEEP_W helper.
- Sub-module xg_sdp_ram: simple dual-port RAM, width DATA_W+KEEP_W+1, depth DEPTH, registered read port.

Test Plan:
- Single frame, 3 words, last keep=8'h0F, DATA_W=64: tx_start rises 1 cycle after commit. MAC acks 5 cycles later. Then words 2 and 3 follow on consecutive cycles with tx_data_valid FF, FF, 0F. frames_sent=1.
- One-word frame, keep=8'h01: tx_start held until ack. tx_data_valid=01 only during the START cycle, then 00. FSM returns to IDLE.
- wr_err=1 on word 2 of a 4-word frame: nothing appears on the TX side, frames_dropped=1. fifo_level returns to its prior value after the last word.
- DEPTH=4, 6-word frame, nothing committed: DISCARD mode is entered, wr_ready stays 1, frames_dropped=1, no tx_start. The next 2-word frame then sends normally.
- Two 2-word frames committed back-to-back: second tx_start asserts the cycle after the first frame's last word. Across 20 frames with random ack delays 0–7, pointers wrap and frames_sent=20.
- reset_n pulsed low during SEND: all outputs go to 0 immediately. After release, fifo_level=0 and the next frame sends cleanly.

Source files
------------

// File: rtl/xg_pkg.sv
// xg_pkg -- shared types and helpers for the 10G MAC TX frame buffer. rev 1.0
`default_nettype none

package xg_pkg;

  // Widest byte-enable the keep helpers handle (DATA_W up to 512).
  localparam int KEEP_MAX = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SEND  = 2'd2
  } txf_state_t;

  function automatic int keep_width(input int data_w);
    return data_w / 8;
  endfunction

  // Nonzero and of the form 0..01..1 (bytes packed from bit 0 upwards).
  function automatic logic keep_contig(input logic [KEEP_MAX-1:0] keep);
    return (keep != '0) && ((keep & (keep + KEEP_MAX'(1))) == '0);
  endfunction

endpackage

`default_nettype wire

// File: rtl/xg_sdp_ram.sv
// xg_sdp_ram -- simple dual-port RAM with one registered read port. rev 1.0
`default_nettype none

module xg_sdp_ram #(
  parameter int WIDTH = 73,
  parameter int DEPTH = 512,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Read returns the old contents on a same-address collision.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/xg_tx_frame_fifo.sv
// xg_tx_frame_fifo -- store-and-forward TX frame buffer for the 10G MAC client. rev 1.0
`default_nettype none

module xg_tx_frame_fifo
  import xg_pkg::*;
#(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 512,
  parameter int CNT_W  = 32,
  localparam int KEEP_W = keep_width(DATA_W),
  localparam int AW     = $clog2(DEPTH),
  localparam int PW     = AW + 1
) (
  input  logic              tx_clk0,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [KEEP_W-1:0] wr_keep,
  input  logic              wr_last,
  input  logic              wr_err,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic [KEEP_W-1:0] tx_data_valid,
  output logic              tx_start,
  input  logic              tx_ack,
  output logic              tx_underrun,
  output logic [CNT_W-1:0]  frames_sent,
  output logic [CNT_W-1:0]  frames_dropped,
  output logic [PW-1:0]     fifo_level
);

  localparam int EW = DATA_W + KEEP_W + 1;

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     commit_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     rd_next;
  logic [PW-1:0]     frames_avail;
  logic              ready_en;
  logic              in_frame;
  logic              frame_bad;
  logic              discard;
  logic              full;
  logic              ovf;
  logic              accept;
  logic              word_bad;
  logic              store;
  logic              commit;
  logic              drop;
  logic              frame_done;
  txf_state_t        state;
  txf_state_t        state_nxt;
  logic [EW-1:0]     ram_rdata;
  logic              q_last;
  logic [KEEP_W-1:0] q_keep;
  logic [DATA_W-1:0] q_data;

  // ---------------- write side ----------------
  assign full     = (wr_ptr - rd_ptr) == PW'(DEPTH);
  // A frame that fills the buffer with nothing committed can never be sent.
  assign ovf      = full && in_frame && (frames_avail == '0) && !discard;
  assign wr_ready = ready_en && (discard || ovf || !full);
  assign accept   = wr_valid && wr_ready;
  assign word_bad = wr_err || (wr_last ? !keep_contig(KEEP_MAX'(wr_keep))
                                       : (wr_keep != '1));
  assign store    = accept && !discard && !ovf;
  assign commit   = store && wr_last && !frame_bad && !word_bad;
  assign drop     = accept && wr_last && !commit;

  always_ff @(posedge tx_clk0 or negedge reset_n) begin
    if (!reset_n) begin
      ready_en   <= 1'b0;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      in_frame   <= 1'b0;
      frame_bad  <= 1'b0;
      discard    <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (accept) begin
        if (discard || ovf) begin
          wr_ptr    <= commit_ptr;
          discard   <= !wr_last;
          in_frame  <= !wr_last;
          frame_bad <= 1'b0;
        end else if (wr_last) begin
          in_frame  <= 1'b0;
          frame_bad <= 1'b0;
          if (commit) begin
            wr_ptr     <= wr_ptr + PW'(1);
            commit_ptr <= wr_ptr + PW'(1);
          end else begin
            wr_ptr <= commit_ptr;
          end
        end else begin
          wr_ptr    <= wr_ptr + PW'(1);
          in_frame  <= 1'b1;
          frame_bad <= frame_bad | word_bad;
        end
      end
    end
  end

  xg_sdp_ram #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_ram (
    .clk   (tx_clk0),
    .we    (store),
    .waddr (wr_ptr[AW-1:0]),
    .wdata ({wr_last, wr_keep, wr_data}),
    .raddr (rd_next[AW-1:0]),
    .rdata (ram_rdata)
  );

  assign {q_last, q_keep, q_data} = ram_rdata;

  // ---------------- read side ----------------
  // The RAM is addressed with rd_next so its output register always holds
  // the word at rd_ptr; IDLE re-reads every cycle to absorb write collisions.
  always_comb begin
    state_nxt  = state;
    rd_next    = rd_ptr;
    frame_done = 1'b0;
    case (state)
      IDLE: begin
        if (frames_avail != '0) begin
          state_nxt = START;
        end
      end
      START: begin
        if (tx_ack) begin
          rd_next = rd_ptr + PW'(1);
          if (q_last) begin
            frame_done = 1'b1;
            state_nxt  = (frames_avail > PW'(1)) ? START : IDLE;
          end else begin
            state_nxt = SEND;
          end
        end
      end
      SEND: begin
        rd_next = rd_ptr + PW'(1);
        if (q_last) begin
          frame_done = 1'b1;
          state_nxt  = (frames_avail > PW'(1)) ? START : IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge tx_clk0 or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      frames_avail   <= '0;
      frames_sent    <= '0;
      frames_dropped <= '0;
    end else begin
      state  <= state_nxt;
      rd_ptr <= rd_next;
      if (commit && !frame_done) begin
        frames_avail <= frames_avail + PW'(1);
      end else if (frame_done && !commit) begin
        frames_avail <= frames_avail - PW'(1);
      end
      if (frame_done && (frames_sent != '1)) begin
        frames_sent <= frames_sent + CNT_W'(1);
      end
      if (drop && (frames_dropped != '1)) begin
        frames_dropped <= frames_dropped + CNT_W'(1);
      end
    end
  end

  assign tx_start      = (state == START);
  assign tx_data       = (state != IDLE) ? q_data : '0;
  assign tx_data_valid = (state != IDLE) ? q_keep : '0;
  assign tx_underrun   = 1'b0;
  assign fifo_level    = wr_ptr - rd_ptr;

endmodule

`default_nettype wire
